uart_rcv_core: RTL and testbench

Parametrised UART receive core: the next generation of the team's serial receive block. It adds runtime-selectable parity (none/even/odd) and a configurable-depth receive FIFO in place of the single-entry buffer. It keeps runtime data size (5–8 bits) and bit period. It sits between the asynchronous `serial_in` pin and the register/bus interface that drains received characters.

---
 rtl/uart_rcv_core.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_uart_rcv_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv_core.sv
// uart_rcv_core
// UART receive core: synchronises the serial line, recovers one frame of
// 5..8 data bits with optional even/odd parity, and queues good characters
// into a show-ahead FIFO. Errors are reported through sticky flags.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   serial_in                raw serial line (idle high)
//   data_size/parity_mode/bit_period  frame format, latched at start detect
//   data_read                pop FIFO head (ignored when empty)
//   err_clear                clear sticky error flags
//   rx_data                  FIFO head, zero when empty
//   data_ready, fifo_count   FIFO status
//   overrun_error, framing_error, parity_error  sticky error flags
module uart_rcv_core #(
    parameter int FIFO_DEPTH = 8,
    parameter int BP_WIDTH   = 14
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            serial_in,
    input  logic [3:0]                      data_size,
    input  logic [1:0]                      parity_mode,
    input  logic [BP_WIDTH-1:0]             bit_period,
    input  logic                            data_read,
    input  logic                            err_clear,
    output logic [7:0]                      rx_data,
    output logic                            data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun_error,
    output logic                            framing_error,
    output logic                            parity_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_LOAD   = 3'd5
    } state_t;

    function automatic logic [3:0] clamp_size(input logic [3:0] sz);
        logic [3:0] r;
        if (sz < 4'd5) begin
            r = 4'd5;
        end else if (sz > 4'd8) begin
            r = 4'd8;
        end else begin
            r = sz;
        end
        return r;
    endfunction

    function automatic logic [BP_WIDTH-1:0] clamp_bp(input logic [BP_WIDTH-1:0] bp);
        logic [BP_WIDTH-1:0] r;
        if (bp < BP_WIDTH'(4)) begin
            r = BP_WIDTH'(4);
        end else begin
            r = bp;
        end
        return r;
    endfunction

    // Returns 1 when the received parity bit disagrees with the data.
    // Unused upper data bits are always zero, so a full-width XOR is safe.
    function automatic logic parity_bad(input logic [7:0] data, input logic pbit, input logic odd);
        return (^data) ^ pbit ^ odd;
    endfunction

    // Synchroniser, edge register and receive FSM state
    logic                sync1_q, s_in_q, prev_q;
    state_t              state_q, state_d;
    logic [BP_WIDTH-1:0] timer_q, timer_d;
    logic [BP_WIDTH-1:0] bp_q, bp_d;
    logic [3:0]          size_q, size_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_bad_q, par_bad_d;
    logic                stop_q, stop_d;

    // FIFO and flag state
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                data_ready_q, data_ready_d;
    logic                ovr_q, ovr_d;
    logic                frm_q, frm_d;
    logic                par_q, par_d;

    logic                start_edge_s;
    logic [BP_WIDTH-1:0] bp_in_s;
    logic                load_s, frame_ok_s, full_s, pop_s, push_s;

    assign start_edge_s = prev_q & ~s_in_q;
    assign bp_in_s      = clamp_bp(bit_period);

    // Receive FSM next-state: every phase waits on a down-counting bit timer
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bp_d      = bp_q;
        size_d    = size_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        stop_d    = stop_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_d   = S_START;
                    bp_d      = bp_in_s;
                    size_d    = clamp_size(data_size);
                    par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd_d = (parity_mode == 2'b10);
                    // The detect cycle itself is t0, so wait half-1 more cycles
                    timer_d   = (bp_in_s >> 1) - BP_WIDTH'(1);
                    bit_idx_d = 3'd0;
                    shift_d   = 8'h00;
                    par_bad_d = 1'b0;
                    stop_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (timer_q == BP_WIDTH'(0)) begin
                    timer_d = bp_q - BP_WIDTH'(1);
                    if (s_in_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    timer_d = timer_q - BP_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (timer_q == BP_WIDTH'(0)) begin
                    timer_d             = bp_q - BP_WIDTH'(1);
                    shift_d[bit_idx_q]  = s_in_q;
                    if ({1'b0, bit_idx_q} == (size_q - 4'd1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - BP_WIDTH'(1);
                end
            end
            S_PARITY: begin
                if (timer_q == BP_WIDTH'(0)) begin
                    timer_d   = bp_q - BP_WIDTH'(1);
                    par_bad_d = parity_bad(shift_q, s_in_q, par_odd_q);
                    state_d   = S_STOP;
                end else begin
                    timer_d = timer_q - BP_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (timer_q == BP_WIDTH'(0)) begin
                    stop_d  = s_in_q;
                    state_d = S_LOAD;
                end else begin
                    timer_d = timer_q - BP_WIDTH'(1);
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load_s     = (state_q == S_LOAD);
    assign frame_ok_s = load_s & stop_q & ~par_bad_q;
    assign full_s     = (count_q == CW'(FIFO_DEPTH));
    assign pop_s      = data_read & data_ready_q;
    // A pop in the LOAD cycle frees a slot, so a full FIFO still accepts
    assign push_s     = frame_ok_s & (~full_s | pop_s);

    // FIFO pointers, count, registered head and sticky flags
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        data_ready_d = (count_d != CW'(0));
        // Head is registered, so it is derived from next-state pointers; a
        // push landing in the next head slot is forwarded around the memory
        if (count_d == CW'(0)) begin
            rx_data_d = 8'h00;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            rx_data_d = shift_q;
        end else begin
            rx_data_d = mem[rd_ptr_d];
        end
        // Set has priority over clear
        if (load_s && !stop_q) begin
            frm_d = 1'b1;
        end else if (err_clear) begin
            frm_d = 1'b0;
        end else begin
            frm_d = frm_q;
        end
        if (load_s && par_bad_q) begin
            par_d = 1'b1;
        end else if (err_clear) begin
            par_d = 1'b0;
        end else begin
            par_d = par_q;
        end
        if (frame_ok_s && full_s && !pop_s) begin
            ovr_d = 1'b1;
        end else if (err_clear) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // All control state, with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            s_in_q       <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= S_IDLE;
            timer_q      <= BP_WIDTH'(0);
            bp_q         <= BP_WIDTH'(4);
            size_q       <= 4'd8;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_bad_q    <= 1'b0;
            stop_q       <= 1'b1;
            rd_ptr_q     <= AW'(0);
            wr_ptr_q     <= AW'(0);
            count_q      <= CW'(0);
            rx_data_q    <= 8'h00;
            data_ready_q <= 1'b0;
            ovr_q        <= 1'b0;
            frm_q        <= 1'b0;
            par_q        <= 1'b0;
        end else begin
            sync1_q      <= serial_in;
            s_in_q       <= sync1_q;
            prev_q       <= s_in_q;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bp_q         <= bp_d;
            size_q       <= size_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_q       <= stop_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            ovr_q        <= ovr_d;
            frm_q        <= frm_d;
            par_q        <= par_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign fifo_count    = count_q;
    assign overrun_error = ovr_q;
    assign framing_error = frm_q;
    assign parity_error  = par_q;

endmodule

// File: tb/tb_uart_rcv_core.sv
// Testbench for uart_rcv_core (FIFO_DEPTH=4). Frames are driven bit by bit;
// good characters are pushed to a scoreboard queue and compared as popped.
module tb_uart_rcv_core;
    localparam int DEPTH = 4;
    localparam int BPW   = 14;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           serial_in = 1'b1;
    logic [3:0]     data_size = 4'd8;
    logic [1:0]     parity_mode = 2'b00;
    logic [BPW-1:0] bit_period = BPW'(16);
    logic           data_read = 1'b0;
    logic           err_clear = 1'b0;
    logic [7:0]     rx_data;
    logic           data_ready;
    logic [CW-1:0]  fifo_count;
    logic           overrun_error, framing_error, parity_error;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    uart_rcv_core #(.FIFO_DEPTH(DEPTH), .BP_WIDTH(BPW)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_size(data_size),
        .parity_mode(parity_mode), .bit_period(bit_period), .data_read(data_read),
        .err_clear(err_clear), .rx_data(rx_data), .data_ready(data_ready),
        .fifo_count(fifo_count), .overrun_error(overrun_error),
        .framing_error(framing_error), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    function automatic logic calc_par(input logic [7:0] d, input int n, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < n; i++) p = p ^ d[i];
        return p;
    endfunction

    // Drive one frame; c counts cycles from the start-bit edge. data_read is
    // raised for one cycle at c==pop_at; rst asserted (frame aborted) at c==rst_at.
    task automatic send_frame(input logic [7:0] data, input int nbits, input int bp,
                              input bit has_par, input logic pbit, input logic stop_val,
                              input int pop_at, input int rst_at, input int idle_after);
        logic [11:0] fb;
        int nf;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < nbits; i++) fb[i+1] = data[i];
        nf = nbits + 1;
        if (has_par) begin fb[nf] = pbit; nf++; end
        fb[nf] = stop_val;
        nf++;
        for (int c = 0; c < nf * bp; c++) begin
            @(posedge clk); #1;
            if (c == rst_at) begin
                rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
                break;
            end
            serial_in = fb[c / bp];
            data_read = (c == pop_at);
        end
        for (int c = 0; c < idle_after; c++) begin
            @(posedge clk); #1;
            serial_in = 1'b1;
            data_read = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(posedge clk); #1;
        data_read = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
        checks++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if ({overrun_error, framing_error, parity_error} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {overrun_error, framing_error, parity_error}); end
        do_reset();
    endtask

    task automatic test_basic_8n1();
        do_reset();
        data_size = 4'd8; parity_mode = 2'b00; bit_period = BPW'(16);
        send_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1'b1, -1, -1, 20);
        exp_q.push_back(8'hA5);
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", data_ready); end
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL basic_count: got %0d expected 1", fifo_count); end
        checks++; if ({overrun_error, framing_error, parity_error} !== 3'b000) begin errors++;
            $display("FAIL basic_flags: got %b expected 000", {overrun_error, framing_error, parity_error}); end
        exp_v = exp_q.pop_front();
        checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL basic_data: got %h expected %h", rx_data, exp_v); end
        pulse_read();
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL basic_pop_ready: got %b expected 0", data_ready); end
        checks++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL basic_pop_count: got %0d expected 0", fifo_count); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL basic_empty_data: got %h expected 00", rx_data); end
    endtask

    task automatic test_even_parity();
        logic p;
        do_reset();
        data_size = 4'd5; parity_mode = 2'b01; bit_period = BPW'(10);
        p = calc_par(8'h13, 5, 1'b0);
        send_frame(8'h13, 5, 10, 1'b1, p, 1'b1, -1, -1, 14);
        exp_q.push_back(8'h13);
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL even_good_perr: got %b expected 0", parity_error); end
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL even_good_count: got %0d expected 1", fifo_count); end
        send_frame(8'h13, 5, 10, 1'b1, ~p, 1'b1, -1, -1, 14);
        checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL even_bad_perr: got %b expected 1", parity_error); end
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL even_bad_count: got %0d expected 1", fifo_count); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL even_bad_ferr: got %b expected 0", framing_error); end
        exp_v = exp_q.pop_front();
        checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL even_data: got %h expected %h", rx_data, exp_v); end
        pulse_read();
    endtask

    task automatic test_framing();
        do_reset();
        data_size = 4'd7; parity_mode = 2'b10; bit_period = BPW'(16);
        send_frame(8'h41, 7, 16, 1'b1, calc_par(8'h41, 7, 1'b1), 1'b0, -1, -1, 0);
        repeat (48) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL frm_set: got %b expected 1", framing_error); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL frm_perr: got %b expected 0", parity_error); end
        checks++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL frm_count: got %0d expected 0", fifo_count); end
        send_frame(8'h42, 7, 16, 1'b1, calc_par(8'h42, 7, 1'b1), 1'b1, -1, -1, 20);
        exp_q.push_back(8'h42);
        checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL frm_next_count: got %0d expected 1", fifo_count); end
        exp_v = exp_q.pop_front();
        checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL frm_next_data: got %h expected %h", rx_data, exp_v); end
        pulse_clear();
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL frm_clear: got %b expected 0", framing_error); end
        pulse_read();
    endtask

    task automatic test_overrun();
        do_reset();
        data_size = 4'd8; parity_mode = 2'b00; bit_period = BPW'(8);
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 8, 8, 1'b0, 1'b0, 1'b1, -1, -1, 12);
            if (k <= DEPTH) exp_q.push_back(8'(k));
        end
        checks++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL ovr_count: got %0d expected 4", fifo_count); end
        checks++; if (overrun_error !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_error); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL ovr_order: got %h expected %h", rx_data, exp_v); end
            pulse_read();
        end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b expected 0", data_ready); end
    endtask

    task automatic test_pop_on_load();
        pulse_clear();
        data_size = 4'd8; parity_mode = 2'b00; bit_period = BPW'(16);
        for (int k = 0; k < DEPTH; k++) begin
            send_frame(8'h11 + 8'(k), 8, 16, 1'b0, 1'b0, 1'b1, -1, -1, 20);
            exp_q.push_back(8'h11 + 8'(k));
        end
        exp_v = exp_q.pop_front();
        checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL pol_head: got %h expected %h", rx_data, exp_v); end
        // LOAD cycle = 3 + bp/2 + 9*bp cycles after the start-bit edge
        send_frame(8'h15, 8, 16, 1'b0, 1'b0, 1'b1, 3 + 8 + 9 * 16, -1, 20);
        exp_q.push_back(8'h15);
        checks++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL pol_count: got %0d expected 4", fifo_count); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL pol_ovr: got %b expected 0", overrun_error); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL pol_order: got %h expected %h", rx_data, exp_v); end
            pulse_read();
        end
    endtask

    task automatic test_glitch();
        do_reset();
        data_size = 4'd8; parity_mode = 2'b00; bit_period = BPW'(16);
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready: got %b expected 0", data_ready); end
        checks++; if ({overrun_error, framing_error, parity_error} !== 3'b000) begin errors++;
            $display("FAIL glitch_flags: got %b expected 000", {overrun_error, framing_error, parity_error}); end
        send_frame(8'h6E, 8, 16, 1'b0, 1'b0, 1'b1, -1, -1, 20);
        checks++; if (rx_data !== 8'h6E) begin errors++; $display("FAIL glitch_after: got %h expected 6e", rx_data); end
        pulse_read();
    endtask

    task automatic test_reset_midframe();
        logic p;
        do_reset();
        data_size = 4'd8; parity_mode = 2'b01; bit_period = BPW'(16);
        p = calc_par(8'h5A, 8, 1'b0);
        send_frame(8'h5A, 8, 16, 1'b1, p, 1'b1, -1, -1, 20);
        send_frame(8'h5A, 8, 16, 1'b1, ~p, 1'b1, -1, -1, 20);
        checks++; if ({fifo_count, parity_error} !== {CW'(1), 1'b1}) begin errors++;
            $display("FAIL rstmid_pre: got count %0d perr %b expected 1 1", fifo_count, parity_error); end
        send_frame(8'h3C, 8, 16, 1'b1, calc_par(8'h3C, 8, 1'b0), 1'b1, -1, 60, 0);
        #1;
        checks++; if ({rx_data, data_ready, fifo_count} !== {8'h00, 1'b0, CW'(0)}) begin errors++;
            $display("FAIL rstmid_fifo: got data %h ready %b count %0d expected 00 0 0", rx_data, data_ready, fifo_count); end
        checks++; if ({overrun_error, framing_error, parity_error} !== 3'b000) begin errors++;
            $display("FAIL rstmid_flags: got %b expected 000", {overrun_error, framing_error, parity_error}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h3C, 8, 16, 1'b1, calc_par(8'h3C, 8, 1'b0), 1'b1, -1, -1, 20);
        checks++; if ({rx_data, fifo_count, parity_error} !== {8'h3C, CW'(1), 1'b0}) begin errors++;
            $display("FAIL rstmid_after: got data %h count %0d perr %b expected 3c 1 0", rx_data, fifo_count, parity_error); end
        pulse_read();
    endtask

    task automatic test_clamps();
        do_reset();
        parity_mode = 2'b00; bit_period = BPW'(2);
        data_size = 4'd8;
        send_frame(8'h96, 8, 4, 1'b0, 1'b0, 1'b1, -1, -1, 8);
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL clamp_bp: got %h expected 96", rx_data); end
        pulse_read();
        data_size = 4'd3;
        send_frame(8'hB6, 5, 4, 1'b0, 1'b0, 1'b1, -1, -1, 8);
        checks++; if (rx_data !== 8'h16) begin errors++; $display("FAIL clamp_size_lo: got %h expected 16", rx_data); end
        pulse_read();
        data_size = 4'd12;
        send_frame(8'hC3, 8, 4, 1'b0, 1'b0, 1'b1, -1, -1, 8);
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL clamp_size_hi: got %h expected c3", rx_data); end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        do_reset();
        data_size = 4'd8; parity_mode = 2'b00; bit_period = BPW'(4);
        // With bp=4 the next start edge reaches s_in the cycle right after LOAD
        for (int k = 0; k < 3; k++) begin
            send_frame(8'h81 + 8'(k * 17), 8, 4, 1'b0, 1'b0, 1'b1, -1, -1, (k == 2) ? 8 : 0);
            exp_q.push_back(8'h81 + 8'(k * 17));
        end
        checks++; if (fifo_count !== CW'(3)) begin errors++; $display("FAIL b2b_count: got %0d expected 3", fifo_count); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++; if (rx_data !== exp_v) begin errors++; $display("FAIL b2b_data: got %h expected %h", rx_data, exp_v); end
            pulse_read();
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_even_parity();
        test_framing();
        test_overrun();
        test_pop_on_load();
        test_glitch();
        test_reset_midframe();
        test_clamps();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
